// File: rtl/message_assembler.sv
// message_assembler: serial-to-word receiver. It hunts for an 8-bit sync
// pattern, reads a LOGSIZE-bit word-count header, then assembles WIDTH-bit
// payload words (MSB first) and writes each one to a BRAM through
// we/waddr/wdata. Long gaps in the bit stream abort the message with err.
//
// Handshake: bit_in is consumed only on cycles where bit_valid=1; there is
// no backpressure, so every valid bit must be taken on the cycle it arrives.
// we is a one-cycle strobe, and waddr/wdata hold their last value while we=0.
//
// Timing of the status outputs: we and err are registered on the edge that
// decides them. busy and done follow the state one cycle later, which puts
// done one cycle after the final we, and drops busy one cycle after done.
module message_assembler #(
    parameter int         WIDTH   = 64,
    parameter int         LOGSIZE = 8,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               we,
    output logic [LOGSIZE-1:0] waddr,
    output logic [WIDTH-1:0]   wdata,
    output logic [LOGSIZE-1:0] msg_len,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // One counter serves both the header and the payload bit positions.
    localparam int MAXB  = (WIDTH > LOGSIZE) ? WIDTH : LOGSIZE;
    localparam int CNT_W = $clog2(MAXB) + 1;

    localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
    localparam logic [LOGSIZE-1:0] ADDR_ONE = 1;
    localparam logic [15:0]        IDLE_ONE = 16'd1;
    localparam logic [15:0]        IDLE_MAX = 16'(TIMEOUT - 1);

    logic [1:0]         r_state;
    // The 8-bit sync window is the 7 stored history bits plus the current bit.
    logic [6:0]         r_sync;
    // The word in flight is the WIDTH-1 stored bits plus the current bit.
    logic [WIDTH-2:0]   r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [15:0]        r_idle_cnt;
    logic [LOGSIZE-1:0] r_addr;
    logic               r_we;
    logic [LOGSIZE-1:0] r_waddr;
    logic [WIDTH-1:0]   r_wdata;
    logic [LOGSIZE-1:0] r_msg_len;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [7:0]         w_sync_next;
    logic [WIDTH-1:0]   w_shift_next;
    logic [LOGSIZE-1:0] w_hdr_val;
    logic               w_hdr_last;
    logic               w_word_last;
    logic               w_msg_last;
    logic               w_timeout;

    // Next-bit views of the shift registers and the end-of-field decodes.
    always_comb begin
        w_sync_next  = {r_sync, bit_in};
        w_shift_next = {r_shift, bit_in};
        w_hdr_val    = w_shift_next[LOGSIZE-1:0];
        w_hdr_last   = (r_bit_cnt == CNT_W'(LOGSIZE - 1));
        w_word_last  = (r_bit_cnt == CNT_W'(WIDTH - 1));
        w_msg_last   = (r_addr == (r_msg_len - ADDR_ONE));
        w_timeout    = !bit_valid && (r_idle_cnt == IDLE_MAX);
    end

    // Receive FSM plus its datapath: sync hunt, header, payload, write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sync     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_msg_len  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bit_valid) begin
                        r_sync <= w_sync_next[6:0];
                        if (w_sync_next == SYNC) begin
                            r_state    <= ST_HEADER;
                            r_bit_cnt  <= '0;
                            r_idle_cnt <= '0;
                            r_shift    <= '0;
                        end
                    end
                end
                ST_HEADER: begin
                    if (bit_valid) begin
                        r_idle_cnt <= '0;
                        r_shift    <= w_shift_next[WIDTH-2:0];
                        if (w_hdr_last) begin
                            r_bit_cnt <= '0;
                            r_msg_len <= w_hdr_val;
                            r_addr    <= '0;
                            r_state   <= (w_hdr_val == '0) ? ST_DONE : ST_PAYLOAD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                        r_sync  <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_ONE;
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_valid) begin
                        r_idle_cnt <= '0;
                        r_shift    <= w_shift_next[WIDTH-2:0];
                        if (w_word_last) begin
                            r_bit_cnt <= '0;
                            r_we      <= 1'b1;
                            r_wdata   <= w_shift_next;
                            r_waddr   <= r_addr;
                            r_addr    <= r_addr + ADDR_ONE;
                            if (w_msg_last) begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        end
                    end else if (w_timeout) begin
                        // The partial word in r_shift is simply abandoned.
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                        r_sync  <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_ONE;
                    end
                end
                ST_DONE: begin
                    // Any bit arriving now is dropped; hunting restarts clean.
                    r_state <= ST_IDLE;
                    r_sync  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sync  <= '0;
                end
            endcase
        end
    end

    // Status flags registered from the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != ST_IDLE);
            r_done <= (r_state == ST_DONE);
        end
    end

    assign we      = r_we;
    assign waddr   = r_waddr;
    assign wdata   = r_wdata;
    assign msg_len = r_msg_len;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
